floating_point_cla: RTL and testbench

FLOATING_POINT_CLA -- requirements
Module: floating_point_cla

---
 rtl/fp_pkg.sv | 29 ++
 rtl/cla_adder.sv | 52 +++++
 rtl/floating_point_cla.sv | 105 ++++++++++
 tb/tb_floating_point_cla.sv | 102 ++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - binary32 field constants and leading-zero helper
package fp_pkg;

  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam int          SIG_W   = FRAC_W + 1;
  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Count of leading zeros in a 24-bit significand; 24 when all bits are zero.
  function automatic logic [4:0] lzc24(input logic [SIG_W-1:0] v);
    logic [4:0] cnt;
    logic       found;
    cnt   = 5'd0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          cnt = cnt + 5'd1;
        end
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - carry-lookahead adder built from 4-bit generate/propagate groups
module cla_adder #(
  parameter int N = 25
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o
);

  localparam int NG = (N + 3) / 4;

  logic [N-1:0]  g;
  logic [N-1:0]  p;
  logic [N-1:0]  c;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_c;

  // Bit generate/propagate, group terms, lookahead group carries, then sum bits.
  always_comb begin
    g     = x_i & y_i;
    p     = x_i ^ y_i;
    grp_g = '0;
    grp_p = '1;
    // Group G/P: the last group may be partial when N is not a multiple of 4.
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (k * 4 + j < N) begin
          grp_g[k] = g[k*4+j] | (p[k*4+j] & grp_g[k]);
          grp_p[k] = grp_p[k] & p[k*4+j];
        end
      end
    end
    // Carry into each group comes from the preceding groups' G/P only.
    grp_c[0] = cin_i;
    for (int k = 1; k < NG; k++) begin
      grp_c[k] = grp_g[k-1] | (grp_p[k-1] & grp_c[k-1]);
    end
    // Within a group, carries are resolved from the group carry-in.
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (i % 4 == 0) begin
        c[i] = grp_c[i/4];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end
    sum_o = p ^ c;
  end

endmodule

// File: rtl/floating_point_cla.sv
// rtl/floating_point_cla.sv - registered binary32 adder with CLA significand path
module floating_point_cla
  import fp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0]       sum_q;
  logic [W-1:0]       sum_d;

  logic               a_nan, b_nan, a_inf, b_inf;
  logic               swap;
  logic               big_s, sml_s;
  logic [EXP_W-1:0]   big_e, sml_e;
  logic [FRAC_W-1:0]  big_f, sml_f;
  logic [SIG_W-1:0]   big_sig, sml_sig, sml_shift;
  logic [EXP_W-1:0]   e_diff;
  logic               eff_sub;
  logic [SIG_W:0]     cla_x, cla_y, cla_r;
  logic               cla_cin;
  logic [4:0]         lz;
  logic [SIG_W-1:0]   norm_sig;
  logic signed [9:0]  norm_e;

  // Classify operands, order by magnitude and align the smaller significand.
  always_comb begin
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    // Ties keep a as the reference; equal magnitudes then only matter for x-x=+0.
    swap  = (b[30:0] > a[30:0]);
    big_s = swap ? b[31]    : a[31];
    big_e = swap ? b[30:23] : a[30:23];
    big_f = swap ? b[22:0]  : a[22:0];
    sml_s = swap ? a[31]    : b[31];
    sml_e = swap ? a[30:23] : b[30:23];
    sml_f = swap ? a[22:0]  : b[22:0];
    // Exponent 0 means zero or subnormal; both are flushed to a zero significand.
    big_sig   = (big_e == '0) ? '0 : {1'b1, big_f};
    sml_sig   = (sml_e == '0) ? '0 : {1'b1, sml_f};
    e_diff    = big_e - sml_e;
    sml_shift = (e_diff >= 8'd24) ? '0 : (sml_sig >> e_diff);
    eff_sub   = big_s ^ sml_s;
    // Subtraction reuses the adder as big + ~small + 1; cin has no effect there.
    cla_x   = {1'b0, big_sig};
    cla_y   = eff_sub ? ~{1'b0, sml_shift} : {1'b0, sml_shift};
    cla_cin = eff_sub ? 1'b1 : cin;
  end

  cla_adder #(
    .N(SIG_W + 1)
  ) u_cla (
    .x_i  (cla_x),
    .y_i  (cla_y),
    .cin_i(cla_cin),
    .sum_o(cla_r)
  );

  // Normalise the adder result, then resolve specials, underflow and overflow.
  always_comb begin
    lz       = lzc24(cla_r[SIG_W-1:0]);
    norm_sig = cla_r[SIG_W-1:0];
    norm_e   = $signed({2'b00, big_e});
    if (!eff_sub && cla_r[SIG_W]) begin
      norm_sig = cla_r[SIG_W:1];
      norm_e   = norm_e + 10'sd1;
    end else if (eff_sub) begin
      norm_sig = cla_r[SIG_W-1:0] << lz;
      norm_e   = norm_e - $signed({5'b00000, lz});
    end

    sum_d = {big_s, norm_e[EXP_W-1:0], norm_sig[FRAC_W-1:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      sum_d = QNAN;
    end else if (a_inf) begin
      sum_d = a;
    end else if (b_inf) begin
      sum_d = b;
    end else if ((norm_sig == '0) || (norm_e < 10'sd1)) begin
      sum_d = '0;
    end else if (norm_e >= 10'(EXP_MAX)) begin
      sum_d = {big_s, 8'hFF, 23'd0};
    end
  end

  // Single output register; reset clears the result and drops any in-flight sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_floating_point_cla.sv
// tb/tb_floating_point_cla.sv - directed self-checking bench for floating_point_cla
module tb_floating_point_cla;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;

  int n_checks;
  int n_errors;

  floating_point_cla #(
    .W(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic [31:0] exp);
    @(negedge clk);
    a   = av;
    b   = bv;
    cin = cv;
    @(posedge clk);
    #1;
    check(tag, sum, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    a        = 32'h3F80_0000;
    b        = 32'h3F80_0000;
    cin      = 1'b0;
    #1;
    check("reset_async", sum, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reset_held", sum, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;

    apply("add_7p4",      32'h404C_CCCC, 32'h4086_6666, 1'b0, 32'h40EC_CCCC);
    apply("neg_add",      32'hBF00_0000, 32'hC0CC_CCCC, 1'b0, 32'hC0DC_CCCC);
    apply("sub_5p9",      32'hBF00_0000, 32'h40CC_CCCC, 1'b0, 32'h40BC_CCCC);
    apply("cancel_1",     32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000);
    apply("cancel_10",    32'h4120_0000, 32'hC120_0000, 1'b0, 32'h0000_0000);
    apply("carry_norm",   32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4040_0000);
    apply("cin_add",      32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000);
    apply("inf_minus",    32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000);
    apply("nan_in",       32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
    apply("neg_inf_pass", 32'h3F80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000);
    apply("overflow",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
    apply("diff_24",      32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
    apply("diff_23",      32'h3F80_0000, 32'h3400_0000, 1'b0, 32'h3F80_0001);
    apply("subnorm_flush",32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h3F80_0000);
    apply("subnorm_zero", 32'h0040_0000, 32'h0040_0000, 1'b1, 32'h0000_0000);
    apply("sub_cin_ign",  32'h4000_0000, 32'hBF80_0000, 1'b1, 32'h3F80_0000);
    apply("lz_shift2",    32'h3F80_0000, 32'hBF40_0000, 1'b0, 32'h3E80_0000);
    apply("underflow",    32'h00C0_0000, 32'h8080_0000, 1'b0, 32'h0000_0000);

    // Mid-stream reset: result visible, then reset must clear it without a clock edge.
    apply("pre_reset",    32'h404C_CCCC, 32'h4086_6666, 1'b0, 32'h40EC_CCCC);
    @(negedge clk);
    a     = 32'h3FC0_0000;
    b     = 32'h3FC0_0000;
    rst_n = 1'b0;
    #1;
    check("mid_reset", sum, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reset_drop", sum, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume", sum, 32'h4040_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
